// File: rtl/slow_tick_pkg.sv
// Shared types for the slow tick timer.
// Holds the timer state encoding and the period reset value.
package slow_tick_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } tmr_state_t;

  localparam int PERIOD_RST = 1;

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronises a slow level input into clk.
// Emits a registered one-cycle pulse per rising edge.
module sync_edge_detect
  import slow_tick_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic slow_in,
  output logic tick
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   level;

  assign level = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      tick   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], slow_in};
      prev_q <= level;
      tick   <= level & ~prev_q;
    end
  end

endmodule

// File: rtl/slow_tick_timer.sv
// Interval timer counting synchronised slow-clock ticks.
// One-shot or periodic, with expiry pulse and sticky irq.
module slow_tick_timer
  import slow_tick_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             slow_in,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic             cfg_load,
  input  logic             cfg_periodic,
  input  logic             start,
  input  logic             stop,
  input  logic             irq_clr,
  output logic             tick,
  output logic             expire,
  output logic             irq,
  output logic             busy,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  tmr_state_t       state;
  tmr_state_t       state_d;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] count_d;
  logic             periodic_q;
  logic             expire_d;
  logic             run_tick;
  logic             last_tick;
  logic             load_ok;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst    (rst),
    .slow_in(slow_in),
    .tick   (tick)
  );

  assign run_tick  = tick && (state == RUN);
  assign last_tick = run_tick && (count == ONE);
  assign load_ok   = cfg_load && (state != RUN);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (stop)
      state_d = IDLE;
    else if (start)
      state_d = RUN;
    else if (last_tick && !periodic_q)
      state_d = DONE;
  end

  // stop beats start beats tick
  always_comb begin
    count_d  = count;
    expire_d = 1'b0;
    if (stop) begin
      count_d = '0;
    end else if (start) begin
      count_d = period_q;
    end else if (last_tick) begin
      expire_d = 1'b1;
      count_d  = periodic_q ? period_q : '0;
    end else if (run_tick && count != '0) begin
      count_d = count - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= '0;
      expire     <= 1'b0;
      irq        <= 1'b0;
      busy       <= 1'b0;
      period_q   <= CNT_W'(PERIOD_RST);
      periodic_q <= 1'b0;
    end else begin
      count  <= count_d;
      expire <= expire_d;
      busy   <= (state_d == RUN);
      if (load_ok) begin
        period_q   <= (cfg_period == '0) ? ONE : cfg_period;
        periodic_q <= cfg_periodic;
      end
      if (expire)       irq <= 1'b1;
      else if (irq_clr) irq <= 1'b0;
    end
  end

endmodule

// File: tb/tb_slow_tick_timer.sv
// Bench for slow_tick_timer: directed scenarios then random traffic.
// Outputs are compared against a behavioural model every cycle.
module tb_slow_tick_timer;

  localparam int SYNC = 2;
  localparam int W    = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         slow_in = 1'b0;
  logic [W-1:0] cfg_period = '0;
  logic         cfg_load = 1'b0;
  logic         cfg_periodic = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         irq_clr = 1'b0;
  logic         tick;
  logic         expire;
  logic         irq;
  logic         busy;
  logic [W-1:0] count;

  slow_tick_timer #(
    .SYNC_STAGES(SYNC),
    .CNT_W      (W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .slow_in     (slow_in),
    .cfg_period  (cfg_period),
    .cfg_load    (cfg_load),
    .cfg_periodic(cfg_periodic),
    .start       (start),
    .stop        (stop),
    .irq_clr     (irq_clr),
    .tick        (tick),
    .expire      (expire),
    .irq         (irq),
    .busy        (busy),
    .count       (count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int half = 0;
  int phase = 0;

  // behavioural model
  bit m_run, m_periodic, m_tick, m_expire, m_irq;
  int m_period, m_count;
  bit samp[$];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_update();
    bit was_run  = m_run;
    bit old_tick = m_tick;
    bit old_exp  = m_expire;
    if (rst) begin
      m_run = 0; m_periodic = 0; m_tick = 0;
      m_expire = 0; m_irq = 0;
      m_period = 1; m_count = 0;
      samp.delete();
      for (int i = 0; i < SYNC + 2; i++) samp.push_back(1'b0);
      return;
    end
    samp.push_front(slow_in);
    void'(samp.pop_back());
    m_tick = samp[SYNC] && !samp[SYNC+1];
    m_expire = 0;
    if (stop) begin
      m_run = 0; m_count = 0;
    end else if (start) begin
      m_run = 1; m_count = m_period;
    end else if (was_run && old_tick) begin
      if (m_count == 1) begin
        m_expire = 1;
        if (m_periodic) m_count = m_period;
        else begin m_count = 0; m_run = 0; end
      end else begin
        m_count = m_count - 1;
      end
    end
    if (cfg_load && !was_run) begin
      m_period   = (cfg_period == 0) ? 1 : int'(cfg_period);
      m_periodic = cfg_periodic;
    end
    if (old_exp) m_irq = 1;
    else if (irq_clr) m_irq = 0;
  endfunction

  task automatic step();
    if (half > 0) begin
      phase++;
      if (phase >= half) begin
        phase = 0;
        slow_in = ~slow_in;
      end
    end
    @(posedge clk);
    model_update();
    #1;
    chk("tick", tick, m_tick);
    chk("expire", expire, m_expire);
    chk("irq", irq, m_irq);
    chk("busy", busy, m_run);
    chk("count", count, m_count);
    start = 0; stop = 0; cfg_load = 0; irq_clr = 0;
  endtask

  task automatic load(int p, bit per);
    cfg_period = W'(p);
    cfg_periodic = per;
    cfg_load = 1;
    step();
  endtask

  initial begin
    int n, nt, nexp, since;
    bit found;
    logic saved_irq;

    repeat (3) step();
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    rst = 0;
    step();

    // one-shot, period 3
    load(3, 0);
    start = 1; step();
    half = 10; phase = 0;
    repeat (100) step();
    chk("oneshot_count", count, 0);
    chk("oneshot_busy", busy, 0);
    chk("oneshot_irq", irq, 1);

    // periodic, period 2, clr collides with a set
    load(2, 1);
    start = 1; step();
    nexp = 0; since = 0;
    for (int i = 0; i < 200 && nexp < 3; i++) begin
      step();
      since++;
      if (nexp == 0 && since == 3) irq_clr = 1;
      if (expire) begin
        nexp++; since = 0;
        chk("per_reload", count, 2);
        if (nexp == 2) irq_clr = 1;
      end
      if (nexp == 1 && since == 5) irq_clr = 1;
    end
    chk("per_expires", nexp, 3);
    step();
    chk("per_irq_set_wins", irq, 1);

    // tick latency and glitch
    stop = 1; step();
    half = 0; slow_in = 0;
    repeat (6) step();
    slow_in = 1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step(); n++;
      if (tick) break;
    end
    chk("tick_latency", n, SYNC + 1);
    repeat (3) step();
    slow_in = 0;
    repeat (5) step();
    slow_in = 1; step(); slow_in = 0;
    nt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (tick) nt++;
    end
    chk("glitch_ticks", nt, 1);

    // stop + start + tick with count 1
    load(3, 0);
    start = 1; step();
    half = 4; phase = 0;
    found = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (m_tick && m_run && m_count == 1) begin found = 1; break; end
    end
    chk("prio_reach", found, 1);
    saved_irq = irq;
    stop = 1; start = 1; step();
    chk("prio_count", count, 0);
    chk("prio_busy", busy, 0);
    chk("prio_expire", expire, 0);
    chk("prio_irq", irq, saved_irq);
    found = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (m_tick) begin found = 1; break; end
    end
    chk("st_reach", found, 1);
    start = 1; step();
    chk("start_tick_count", count, 3);

    // period 0 means 1
    stop = 1; step();
    load(0, 0);
    start = 1; step();
    nt = 0; found = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (expire) begin found = 1; break; end
      if (tick) nt++;
    end
    chk("p0_expired", found, 1);
    chk("p0_ticks", nt, 1);

    // load ignored while running
    load(4, 1);
    start = 1; step();
    load(5, 0);
    stop = 1; step();
    start = 1; step();
    chk("run_load_ignored", count, 4);

    // full-range period, no wrap
    stop = 1; step();
    load(255, 0);
    start = 1; step();
    half = 2; phase = 0;
    found = 0;
    for (int i = 0; i < 1200; i++) begin
      step();
      if (expire) begin found = 1; break; end
    end
    chk("full_expired", found, 1);
    chk("full_count", count, 0);

    // reset mid-run
    load(9, 0);
    start = 1; step();
    half = 6; phase = 0;
    found = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (m_count == 7) begin found = 1; break; end
    end
    chk("mid_reach", found, 1);
    chk("mid_irq", irq, 1);
    half = 0; slow_in = 1;
    rst = 1; step();
    chk("mid_rst_count", count, 0);
    chk("mid_rst_irq", irq, 0);
    slow_in = 0;
    repeat (2) step();
    rst = 0;
    nt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (tick) nt++;
    end
    chk("rst_edge_dropped", nt, 0);
    start = 1; step();
    chk("rst_period", count, 1);

    // random traffic
    half = 3; phase = 0;
    for (int i = 0; i < 3000; i++) begin
      if (phase == 0) half = int'($urandom_range(2, 7));
      start   = ($urandom_range(0, 19) == 0);
      stop    = ($urandom_range(0, 49) == 0);
      irq_clr = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 14) == 0) begin
        cfg_period   = W'($urandom_range(0, 6));
        cfg_periodic = 1'($urandom_range(0, 1));
        cfg_load     = 1;
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/slow_tick_timer.md
# slow_tick_timer

Programmable interval timer that consumes the divided clock produced by the team's clock divider. It treats that slow clock as an asynchronous level input and synchronises it into the `clk` domain. Each rising edge becomes a one-cycle `tick` enable, and the timer counts those ticks down from a programmed period. On expiry it raises a pulse and a sticky interrupt, in one-shot or periodic mode. It sits between the divider and any control logic that needs slow, exact-count timing without using a divided clock as a clock.

## Interface
Parameters:
- `SYNC_STAGES`, default 2 — synchroniser depth on `slow_in`; legal range ≥ 2.
- `CNT_W`, default 16 — width of the period register and the counter.

Ports:
- `clk` input 1 — system clock; every flop is on `posedge clk`.
- `rst` input 1 — synchronous, active-high reset.
- `slow_in` input 1 — divided clock; asynchronous to `clk`.
- `cfg_period` input CNT_W — period in ticks; a value of 0 is treated as 1.
- `cfg_load` input 1 — latch `cfg_period` into `period_q`.
- `cfg_periodic` input 1 — mode, latched together with `cfg_period`: 1 = periodic, 0 = one-shot.
- `start` input 1 — single-cycle pulse that arms or re-arms the timer.
- `stop` input 1 — single-cycle pulse that aborts the timer.
- `irq_clr` input 1 — clears `irq`.
- `tick` output 1 — one-cycle pulse per synchronised rising edge of `slow_in`.
- `expire` output 1 — one-cycle pulse when the count reaches its end.
- `irq` output 1 — sticky expiry flag.
- `busy` output 1 — high while `state == RUN`.
- `count` output CNT_W — ticks remaining.

## Operation
- States and transitions:
  - IDLE: `start` → RUN.
  - RUN: `stop` → IDLE; one-shot expiry → DONE; periodic expiry stays in RUN.
  - DONE: `start` → RUN; `stop` → IDLE.
- Config load:
  - `cfg_load` takes effect only in IDLE and DONE; it is ignored in RUN.
  - `period_q <= (cfg_period == 0) ? 1 : cfg_period`.
  - `periodic_q <= cfg_periodic` in the same cycle.
- Start:
  - `count <= period_q`, `state <= RUN`.
  - `start` while in RUN restarts the timer by reloading `count`.
- Tick handling in RUN:
  - `count > 1`: `count <= count - 1`.
  - `count == 1`: `expire` pulses and `irq` is set.
  - On that expiry, periodic mode does `count <= period_q`; one-shot mode does `count <= 0` and goes to DONE.
- Ticks that arrive in IDLE or DONE still drive `tick` but do not change `count`.
- Simultaneous events (priority):
  - `stop` > `start` > tick.
  - `stop` forces IDLE with `count <= 0` and no `expire`.
  - `start` together with a tick reloads `count`; that tick is not counted.
  - `cfg_load` together with `start` in IDLE: the new `period_q` is not yet visible, so `start` loads the old value.
- `irq`:
  - Set by `expire`, cleared by `irq_clr`.
  - If both happen in the same cycle, set wins.
- Arithmetic: unsigned; `count` never wraps below 0 and never exceeds `period_q`.
- Reset (and reset mid-run):
  - State → IDLE.
  - `count`, `tick`, `expire`, `irq`, `busy`, sync flops, edge register → 0.
  - `period_q` → 1, `periodic_q` → 0.
  - Any in-flight edge is discarded.

## Timing
- Tick latency:
  - `slow_in` is first sampled high at edge E; `tick` is high in the cycle after edge E+SYNC_STAGES.
  - Total latency is SYNC_STAGES+1 clocks.
- `tick` spacing:
  - `tick` is exactly 1 cycle wide.
  - With a divider ratio D, ticks are 2·D clocks apart.
  - Requirement: `slow_in` must stay high for ≥ 2 `clk` cycles and low for ≥ 2 `clk` cycles.
- `expire` is asserted in the same cycle `count` transitions from 1.
- `irq` rises one cycle after `expire`.
- `busy` rises in the cycle after the `start` edge.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Package `slow_tick_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, RUN, DONE} tmr_state_t`.
  - Localparam `PERIOD_RST = 1`.
- Sub-module `sync_edge_detect`:
  - Contents: SYNC_STAGES flop chain, previous-value register, registered rising-edge pulse.
  - Parameter: `SYNC_STAGES`.
  - Reused for any other divided-clock consumer.
- The top level holds the FSM, `period_q`/`periodic_q`, the down-counter and the `irq` flag.

## Test plan
- **One-shot:** reset, then `cfg_load` with period=3, one-shot, then `start`, with `slow_in` toggling every 10 clks.
  - `count` goes 3→2→1→0.
  - `expire` pulses on the 3rd tick; `irq`=1; state DONE; `busy`=0.
  - The 4th tick leaves `count` at 0.
- **Periodic:** period=2, periodic.
  - `expire` pulses on ticks 2, 4 and 6; `count` reloads to 2 each time.
  - `irq_clr` on the same cycle as the 4th-tick set leaves `irq`=1.
- **Tick latency:** `slow_in` rises between edges.
  - `tick` appears exactly SYNC_STAGES+1 edges after the first high sample.
  - A 1-cycle-wide high glitch produces at most one `tick`.
- **Priority:** `stop`, `start` and a tick in the same cycle in RUN with `count`=1.
  - Result: IDLE, `count`=0, no `expire`, `irq` unchanged.
  - Then `start`+tick: `count`=period_q, not decremented.
- **Config corner cases:**
  - `cfg_period`=0 gives period 1, so `expire` on the first tick.
  - `cfg_load` in RUN with 5 leaves `period_q` unchanged.
  - Period 2^CNT_W−1 counts down fully without wrapping.
- **Reset mid-run:** `rst` asserted in RUN with `count`=7 and `irq`=1.
  - Next cycle: all outputs 0, `period_q`=1.
  - A `slow_in` edge in flight during reset produces no `tick`.
